// File: rtl/dds_update_scheduler.sv
// dds_update_scheduler: round-robin dispatch of pending freq/phase/amp words to a DDS controller
module dds_update_scheduler #(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic [47:0] freq_in,
    input  logic        freq_dv_in,
    input  logic [13:0] phase_in,
    input  logic        phase_dv_in,
    input  logic [9:0]  amp_in,
    input  logic        amp_dv_in,
    input  logic        dds_done_in,
    output logic [47:0] freq_out,
    output logic [13:0] phase_out,
    output logic [9:0]  amp_out,
    output logic        freq_dv_out,
    output logic        phase_dv_out,
    output logic        amp_dv_out,
    output logic        busy_out,
    output logic        overwrite_out,
    output logic        timeout_out,
    output logic [15:0] update_count_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLDOFF} state_t;
    state_t      state, state_nxt;
    logic [47:0] freq_pend;
    logic [13:0] phase_pend;
    logic [9:0]  amp_pend;
    logic [2:0]  flags, dv, rot, grant, sum;
    logic [1:0]  rr_ptr, sel, gi;
    logic [15:0] cnt;
    logic        dispatch, done_hit, timeout_hit, holdoff_end;

    assign dv          = {amp_dv_in, phase_dv_in, freq_dv_in};
    assign rot         = rr_ptr == 2'd0 ? flags : rr_ptr == 2'd1 ? {flags[0], flags[2:1]} : {flags[1:0], flags[2]};
    assign sel         = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
    assign sum         = {1'b0, rr_ptr} + {1'b0, sel};
    assign gi          = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
    assign grant       = 3'b001 << gi;
    assign dispatch    = state == IDLE && enable_in && |flags;
    assign done_hit    = state == WAIT_DONE && dds_done_in;
    assign timeout_hit = state == WAIT_DONE && !dds_done_in && cnt == 16'(TIMEOUT_CYCLES - 1);
    assign holdoff_end = state == HOLDOFF && cnt == 16'(HOLDOFF_CYCLES - 1);
    assign busy_out    = state != IDLE;

    // next-state selection; ISSUE always lasts a single cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      state_nxt = dispatch ? ISSUE : IDLE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: state_nxt = (done_hit || timeout_hit) ? HOLDOFF : WAIT_DONE;
            HOLDOFF:   state_nxt = holdoff_end ? IDLE : HOLDOFF;
        endcase
    end

    // state, shared wait/holdoff counter (0 in the dispatch cycle and on holdoff entry), round-robin pointer
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= (dispatch || done_hit || timeout_hit) ? '0 : state == IDLE ? cnt : cnt + 16'd1;
            rr_ptr <= dispatch ? (gi == 2'd2 ? 2'd0 : gi + 2'd1) : rr_ptr;
        end
    end

    // pending capture: a new dv always wins over the dispatch clear of the same field
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            flags      <= '0;
            freq_pend  <= '0;
            phase_pend <= '0;
            amp_pend   <= '0;
        end else begin
            flags <= (flags & ~(dispatch ? grant : 3'b000)) | dv;
            if (freq_dv_in) freq_pend <= freq_in;
            if (phase_dv_in) phase_pend <= phase_in;
            if (amp_dv_in) amp_pend <= amp_in;
        end
    end

    // registered outputs: only the granted word moves, strobes and pulses last one cycle
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            freq_out         <= '0;
            phase_out        <= '0;
            amp_out          <= '0;
            {amp_dv_out, phase_dv_out, freq_dv_out} <= '0;
            overwrite_out    <= 1'b0;
            timeout_out      <= 1'b0;
            update_count_out <= '0;
        end else begin
            if (dispatch && grant[0]) freq_out <= freq_pend;
            if (dispatch && grant[1]) phase_out <= phase_pend;
            if (dispatch && grant[2]) amp_out <= amp_pend;
            {amp_dv_out, phase_dv_out, freq_dv_out} <= dispatch ? grant : 3'b000;
            overwrite_out    <= |(dv & flags);
            timeout_out      <= timeout_hit;
            update_count_out <= update_count_out + {15'd0, done_hit};
        end
    end
endmodule

// File: doc/dds_update_scheduler.md
DDS_UPDATE_SCHEDULER -- requirements
Module: dds_update_scheduler

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 16: minimum idle cycles between the end of one DDS transaction and the next dispatch (range 1..65535).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent waiting for dds_done_in before the transaction is abandoned (range 2..65535).
REQ-003 Ports SHALL be:
- clk_in  in  1  system clock; the only clock.
- reset_in  in  1  synchronous, active-high reset.
- enable_in  in  1  1 = dispatch allowed; 0 = capture only, no dispatch.
- freq_in  in  48  frequency word from the output preprocessor.
- freq_dv_in  in  1  freq_in valid, single-cycle pulse.
- phase_in  in  14  phase word.
- phase_dv_in  in  1  phase_in valid.
- amp_in  in  10  amplitude word.
- amp_dv_in  in  1  amp_in valid.
- dds_done_in  in  1  DDS controller transaction-complete pulse.
- freq_out  out  48  frequency word to the DDS controller.
- phase_out  out  14  phase word to the DDS controller.
- amp_out  out  10  amplitude word to the DDS controller.
- freq_dv_out / phase_dv_out / amp_dv_out  out  1 each  single-cycle dispatch strobes.
- busy_out  out  1  high whenever state is not IDLE.
- overwrite_out  out  1  one-cycle pulse when a pending, undispatched value is replaced.
- timeout_out  out  1  one-cycle pulse when a transaction is abandoned.
- update_count_out  out  16  completed-transaction counter; wraps at 0xFFFF -> 0.

Function
REQ-004 Each field (freq, phase, amp) SHALL have a pending register plus a pending flag; a dv_in pulse loads the value and sets the flag on the same clock edge, in any state.
REQ-005 A dv_in for a field whose flag is already set SHALL overwrite the value and pulse overwrite_out on the next cycle (one pulse even if several fields overwrite in the same cycle).
REQ-006 States SHALL be IDLE, ISSUE, WAIT_DONE and HOLDOFF.
REQ-007 IDLE -> ISSUE when enable_in=1 and at least one flag is set; otherwise the block stays in IDLE.
REQ-008 Arbitration SHALL be round-robin over the order freq -> phase -> amp -> freq, starting from the field after the last one granted; the grant pointer after reset is freq.
REQ-009 In ISSUE (exactly 1 cycle) the block SHALL copy the granted pending value into its *_out register, assert only that field's dv_out for this cycle, clear that field's flag, and go to WAIT_DONE.
REQ-010 If a dv_in for the granted field arrives in the ISSUE cycle, the new value SHALL be captured and the flag SHALL remain set; capture wins over clear, and no overwrite_out pulse is generated.
REQ-011 *_out registers SHALL hold their value until that field's next dispatch; ungranted *_out registers SHALL never change.
REQ-012 WAIT_DONE -> HOLDOFF on dds_done_in=1, and update_count_out SHALL increment by 1 on the same edge.
REQ-013 WAIT_DONE -> HOLDOFF when the wait counter reaches TIMEOUT_CYCLES-1 without dds_done_in; timeout_out pulses for 1 cycle and update_count_out is not incremented.
REQ-014 If dds_done_in and the timeout occur in the same cycle, done wins: no timeout_out pulse, and the counter increments.
REQ-015 dds_done_in SHALL be ignored in every state other than WAIT_DONE.
REQ-016 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles, then go to IDLE.
REQ-017 Dispatch latency: a dv_in arriving in IDLE with enable_in=1 SHALL produce dv_out 2 cycles later (cycle N capture, N+1 ISSUE, dv_out high during N+1 as a registered output, visible after the N+1 edge).
REQ-018 Deasserting enable_in outside IDLE SHALL NOT abort the current transaction; it only blocks the next IDLE -> ISSUE transition.

Reset
REQ-019 On reset_in=1 at a clock edge, the block SHALL enter IDLE, clear all flags, and zero all *_out, dv_out, busy_out, overwrite_out, timeout_out, update_count_out and internal counters; the grant pointer returns to freq.
REQ-020 Reset SHALL take priority over every concurrent dv_in and dds_done_in, including a reset asserted mid-transaction.

Verification
REQ-021 Scenario: freq_dv_in with 0x123456789ABC in IDLE; done returned 5 cycles after dispatch -> freq_dv_out 1 cycle with freq_out=0x123456789ABC; update_count_out=1; busy_out drops after HOLDOFF_CYCLES.
REQ-022 Scenario: freq, phase and amp dv pulsed in the same cycle -> three dispatches in the order freq, phase, amp, each separated by done plus holdoff; only 1 dv_out is high per dispatch.
REQ-023 Scenario: freq re-pulsed on every done while phase is pending -> phase is granted next; amp is never starved.
REQ-024 Scenario: dds_done_in held at 0 -> timeout_out pulses TIMEOUT_CYCLES cycles after dispatch; counter unchanged; next pending field is then dispatched.
REQ-025 Scenario: phase 0x0100 then 0x0200 pulsed while enable_in=0 -> overwrite_out pulses once; after enable_in=1, a single dispatch with phase_out=0x0200.
REQ-026 Scenario: reset_in asserted during WAIT_DONE with amp pending -> all outputs 0, IDLE, no dispatch after release until a new dv_in.
